// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the CPU control FSM and its neighbours: instruction
// memory handshake, register-file read/write controls and ALU controls.
//   master : control FSM side (drives fetch request, ALU and regfile controls)
//   slave  : memory / regfile / ALU side (returns fetch data, rs1 data, zero flag)
interface cpu_ctrl_fsm_if;
    // instruction memory handshake
    logic [7:0] instr_addr;
    logic       instr_req;
    logic       instr_valid;
    logic [7:0] instr_rdata;
    // register-file read side
    logic [1:0] rs1_addr;
    logic [1:0] rs2_addr;
    logic [7:0] rs1_data;
    // ALU controls and status
    logic [1:0] alu_op;
    logic       imm_sel;
    logic [1:0] imm2;
    logic       zero_flag;
    // register-file writeback
    logic       wb_en;
    logic [1:0] wb_addr;
    logic       wb_sel;
    logic [7:0] wb_imm;
    // status
    logic       halted;

    modport master (
        output instr_addr, instr_req, rs1_addr, rs2_addr,
               alu_op, imm_sel, imm2, wb_en, wb_addr, wb_sel, wb_imm, halted,
        input  instr_valid, instr_rdata, rs1_data, zero_flag
    );

    modport slave (
        input  instr_addr, instr_req, rs1_addr, rs2_addr,
               alu_op, imm_sel, imm2, wb_en, wb_addr, wb_sel, wb_imm, halted,
        output instr_valid, instr_rdata, rs1_data, zero_flag
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU.
// Fetches instruction bytes over a req/valid handshake, decodes them and
// sequences the ALU, register file and branch resolution.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : cpu_ctrl_fsm_if.master -- fetch handshake, regfile and ALU controls
// Outputs on the bus are decoded from the registered state/PC/IR/imm byte;
// instr_req and wb_en are additionally masked by rst so a reset cycle
// neither accepts a fetch nor writes the register file.
module cpu_ctrl_fsm #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    cpu_ctrl_fsm_if.master    bus
);

    localparam int unsigned PC_W = 8;
    localparam int unsigned IR_W = 8;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_FETCH2 = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_BZ   = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_NULL = 2'b11;

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [IR_W-1:0] ir_q,    ir_d;
    logic [7:0]      imm_q,   imm_d;

    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] alu_op_c;
    logic       is_imm_c;
    logic       instr_req_c;

    // IR[2] carries no meaning in this ISA
    logic unused_ir2;
    assign unused_ir2 = ir_q[2];

    assign op = ir_q[7:5];
    assign rd = ir_q[4:3];
    assign rs = ir_q[1:0];

    // ALU function and operand select for the register/immediate ALU ops
    always_comb begin
        alu_op_c = ALU_NULL;
        is_imm_c = 1'b0;
        case (op)
            OP_ADD:  alu_op_c = ALU_ADD;
            OP_SUB:  alu_op_c = ALU_SUB;
            OP_NAND: alu_op_c = ALU_NAND;
            OP_ADDI: begin alu_op_c = ALU_ADD; is_imm_c = 1'b1; end
            OP_SUBI: begin alu_op_c = ALU_SUB; is_imm_c = 1'b1; end
            default: alu_op_c = ALU_NULL;
        endcase
    end

    // state, PC, IR and immediate byte registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    // next-state and output decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        instr_req_c = 1'b0;

        bus.instr_addr = pc_q;
        bus.instr_req  = 1'b0;
        bus.rs1_addr   = rd;
        bus.rs2_addr   = rs;
        bus.alu_op     = ALU_NULL;
        bus.imm_sel    = 1'b0;
        bus.imm2       = 2'b00;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = rd;
        bus.wb_sel     = 1'b0;
        bus.wb_imm     = imm_q;
        bus.halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_req_c   = ~rst;
                bus.instr_req = instr_req_c;
                if (instr_req_c && bus.instr_valid) begin
                    ir_d    = bus.instr_rdata;
                    pc_d    = PC_W'(pc_q + PC_W'(1));
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (op)
                    OP_LDI:  state_d = S_FETCH2;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                if (op == OP_BZ) begin
                    // ALU held on NULL so zero_flag reflects the last ALU op
                    if (bus.zero_flag) begin
                        pc_d = bus.rs1_data;
                    end
                    state_d = S_FETCH;
                end else begin
                    bus.alu_op  = alu_op_c;
                    bus.imm_sel = is_imm_c;
                    bus.imm2    = is_imm_c ? rs : 2'b00;
                    state_d     = S_WB;
                end
            end

            S_WB: begin
                bus.wb_en = ~rst;
                if (op == OP_LDI) begin
                    bus.wb_sel = 1'b1;
                end else begin
                    // keep ALU inputs as in EXEC so the result is stable
                    bus.alu_op  = alu_op_c;
                    bus.imm_sel = is_imm_c;
                    bus.imm2    = is_imm_c ? rs : 2'b00;
                end
                state_d = S_FETCH;
            end

            S_FETCH2: begin
                instr_req_c   = ~rst;
                bus.instr_req = instr_req_c;
                if (instr_req_c && bus.instr_valid) begin
                    imm_d   = bus.instr_rdata;
                    pc_d    = PC_W'(pc_q + PC_W'(1));
                    state_d = S_WB;
                end
            end

            S_HALT: begin
                bus.halted = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

endmodule
